// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR feed a byte FIFO drained by a serializer FSM.
// Status word {overflow, empty, full, busy} for the load-side read mux; stores to STAT_ADDR clear overflow.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] StatusData,
  output logic        tx,
  output logic        busy
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              tx_nxt;
  logic              baud_done, push_req, push_ok, pop, clr_ovf;
  logic              fifo_full, fifo_empty;
  logic              unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign baud_done  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign push_req   = MemWrite && (DataAdr == TX_ADDR);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign clr_ovf    = MemWrite && (DataAdr == STAT_ADDR) && WriteData[1];

  assign StatusData = {28'b0, overflow, fifo_empty, fifo_full, busy};

  // FIFO bookkeeping and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= WriteData[7:0];
  end

  // FSM state register plus serializer datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  // Next state; a pop happens from IDLE or on the last cycle of STOP.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values; tx is computed from the next state so the line flop switches on the entry edge.
  always_comb begin
    baud_nxt  = baud_done ? '0 : baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    if (state == IDLE) baud_nxt = '0;
    if (pop) begin
      shift_nxt = mem[rd_ptr];
      bit_nxt   = '0;
      baud_nxt  = '0;
    end else if ((state == DATA) && baud_done) begin
      shift_nxt = shift >> 1;
      bit_nxt   = bit_cnt + 3'd1;
    end
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_mmio_uart_tx;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] StatusData;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frames_seen = 0;
  logic [7:0] exp_q [$];
  int frame_starts [$];

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TX_ADDR     (32'h0000_0100),
    .STAT_ADDR   (32'h0000_0104)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .StatusData(StatusData),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Call at posedge+#1; the store is sampled on the next rising edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Line monitor: samples mid-bit on negedges, aborts the frame if reset is seen.
  initial begin : monitor
    logic [9:0] frame;
    bit         abort;
    int         t0;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        t0    = cyc;
        abort = 1'b0;
        for (int b = 0; b < 10; b++) begin
          repeat ((b == 0) ? 2 : 4) begin
            @(negedge clk);
            if (reset) abort = 1'b1;
          end
          frame[b] = tx;
        end
        if (!abort) begin
          frames_seen++;
          frame_starts.push_back(t0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %h want none (cycle %0d)", frame[8:1], cyc);
          end else begin
            want = exp_q.pop_front();
            check("frame_data", 32'(frame[8:1]), 32'(want));
            check("frame_start_stop", 32'({frame[9], frame[0]}), 32'h2);
          end
        end
      end
    end
  end

  initial begin : stim
    int fs;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_status", StatusData, 32'h4);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single byte with exact edge timing
    exp_q.push_back(8'hA5);
    store(32'h0000_0100, 32'hFFFF_FFA5);
    check("single_tx_pushedge", 32'(tx), 32'h1);
    check("single_busy_pushedge", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("single_tx_start", 32'(tx), 32'h0);
    check("single_busy_start", 32'(busy), 32'h1);
    check("single_status_start", StatusData, 32'h5);
    repeat (3) @(posedge clk);
    #1;
    check("single_tx_start_end", 32'(tx), 32'h0);
    @(posedge clk);
    #1;
    check("single_tx_bit0", 32'(tx), 32'h1);
    repeat (35) @(posedge clk);
    #1;
    check("single_busy_last", 32'(busy), 32'h1);
    check("single_tx_stop", 32'(tx), 32'h1);
    @(posedge clk);
    #1;
    check("single_busy_done", 32'(busy), 32'h0);
    check("single_status_done", StatusData, 32'h4);
    wait_drain("single_drain");

    // Back-to-back frames with no idle gap
    frame_starts.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    store(32'h0000_0100, 32'h0000_0055);
    store(32'h0000_0100, 32'h0000_000F);
    wait_drain("b2b_drain");
    check("b2b_nframes", 32'(frame_starts.size()), 32'h2);
    if (frame_starts.size() == 2)
      check("b2b_spacing", 32'(frame_starts[1] - frame_starts[0]), 32'd40);

    // Overflow: sixth store dropped, sticky flag, clear only with bit 1
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) store(32'h0000_0100, 32'(i));
    check("ovf_status_set", StatusData, 32'hB);
    store(32'h0000_0104, 32'hFFFF_FFFD);
    check("ovf_status_noclear", StatusData, 32'hB);
    store(32'h0000_0104, 32'h0000_0002);
    check("ovf_status_clear", StatusData, 32'h3);
    wait_drain("ovf_drain");
    check("ovf_status_idle", StatusData, 32'h4);

    // Full FIFO plus push on the STOP-exit pop edge
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    store(32'h0000_0100, 32'h0000_0011);
    store(32'h0000_0100, 32'h0000_0022);
    store(32'h0000_0100, 32'h0000_0033);
    store(32'h0000_0100, 32'h0000_0044);
    store(32'h0000_0100, 32'h0000_0055);
    check("full_status_filled", StatusData, 32'h3);
    repeat (36) @(posedge clk);
    #1;
    check("full_status_prepop", StatusData, 32'h3);
    store(32'h0000_0100, 32'h0000_0066);
    check("full_status_poppush", StatusData, 32'h3);
    wait_drain("full_drain");
    check("full_status_idle", StatusData, 32'h4);

    // Reset in DATA bit 3 with two bytes queued
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    store(32'h0000_0100, 32'h0000_00F0);
    store(32'h0000_0100, 32'h0000_0081);
    store(32'h0000_0100, 32'h0000_007E);
    repeat (15) @(posedge clk);
    #1;
    check("midrst_tx_bit3", 32'(tx), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", 32'(tx), 32'h1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_status", StatusData, 32'h4);
    reset = 1'b0;
    exp_q.delete();
    fs = frames_seen;
    repeat (100) @(posedge clk);
    #1;
    check("midrst_noframes", 32'(frames_seen - fs), 32'h0);
    check("midrst_tx_idle", 32'(tx), 32'h1);
    check("midrst_status_idle", StatusData, 32'h4);

    // Address decode: none of these may push or touch status
    store(32'h0000_0104, 32'h0000_0041);
    store(32'h0000_0108, 32'h0000_00AA);
    store(32'h0000_1100, 32'h0000_00BB);
    store(32'h8000_0100, 32'h0000_00CC);
    check("dec_busy", 32'(busy), 32'h0);
    check("dec_status", StatusData, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    check("dec_tx", 32'(tx), 32'h1);
    check("dec_status_late", StatusData, 32'h4);

    wait_drain("final_drain");
    repeat (60) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
